// File: rtl/udm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udm_pkg
// Description : Shared widths, FSM state type and round-robin pick function
//               for the approximate-multiplier share controller.
// Revision    : 1.0  initial release
// ============================================================================
package udm_pkg;

    localparam int UDM_OPW    = 8;
    localparam int UDM_RESW   = 16;
    localparam int UDM_MAXREQ = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RESP = 2'd2
    } udm_state_t;

    // First valid index searching from last+1, wrapping at n requesters.
    // Returns 0 when nothing is valid; callers qualify with |valid.
    function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                           input logic [2:0] last,
                                           input int         n);
        logic [3:0] idx;
        logic       found;
        logic [2:0] pick;
        pick  = '0;
        found = 1'b0;
        for (int i = 1; i <= UDM_MAXREQ; i++) begin
            idx = 4'(last) + 4'(i);
            if (idx >= 4'(n)) begin
                idx = idx - 4'(n);
            end
            if ((i <= n) && !found && valid[idx[2:0]]) begin
                pick  = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/underdesigned_multiplier8.sv
`default_nettype none
// ============================================================================
// Module      : underdesigned_multiplier8
// Description : 8x8 combinational approximate multiplier built from 2x2
//               blocks where 3*3 yields 7; partial products are summed
//               exactly.
// Revision    : 1.0  initial release
// ============================================================================
module underdesigned_multiplier8 (
    input  logic [7:0]  operand1_i,
    input  logic [7:0]  operand2_i,
    output logic [15:0] result_o
);

    logic [3:0]  w_pp [16];
    logic [15:0] w_sum;

    for (genvar i = 0; i < 4; i++) begin : g_row
        for (genvar j = 0; j < 4; j++) begin : g_col
            logic [1:0] w_a;
            logic [1:0] w_b;
            assign w_a = operand1_i[2*i +: 2];
            assign w_b = operand2_i[2*j +: 2];
            assign w_pp[i*4+j] = (w_a == 2'd3 && w_b == 2'd3) ? 4'd7
                                                              : (4'(w_a) * 4'(w_b));
        end
    end

    // Weighted sum of all 2x2 partial products.
    always_comb begin
        w_sum = '0;
        for (int k = 0; k < 16; k++) begin
            w_sum = w_sum + (16'(w_pp[k]) << (2 * ((k / 4) + (k % 4))));
        end
    end

    assign result_o = w_sum;

endmodule
`default_nettype wire

// File: rtl/udm8_share_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : udm8_share_ctrl
// Description : Round-robin scheduler sharing one underdesigned_multiplier8
//               between NREQ valid/ready requesters, with a single tagged,
//               registered response channel.
//               Optional macro UDM_ERR_MON_EN adds rsp_err_o, the registered
//               (exact - approximate) product difference modulo 2^16.
// Revision    : 1.0  initial release
// ============================================================================
module udm8_share_ctrl
    import udm_pkg::*;
#(
    parameter int NREQ    = 2,
    parameter int MUL_LAT = 1,
    parameter int IDW     = 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NREQ-1:0]         req_valid_i,
    output logic [NREQ-1:0]         req_ready_o,
    input  logic [NREQ*UDM_OPW-1:0] op_a_i,
    input  logic [NREQ*UDM_OPW-1:0] op_b_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [IDW-1:0]          rsp_id_o,
    output logic [UDM_RESW-1:0]     rsp_result_o,
    output logic                    busy_o
`ifdef UDM_ERR_MON_EN
    ,
    output logic [UDM_RESW-1:0]     rsp_err_o
`endif
);

    localparam logic [1:0] c_CNT_INIT = 2'(MUL_LAT - 1);

    udm_state_t          r_state;
    udm_state_t          w_state_nxt;
    logic [UDM_OPW-1:0]  r_op_a;
    logic [UDM_OPW-1:0]  r_op_b;
    logic [UDM_OPW-1:0]  w_sel_a;
    logic [UDM_OPW-1:0]  w_sel_b;
    logic [IDW-1:0]      r_id;
    logic [IDW-1:0]      r_last;
    logic [IDW-1:0]      w_grant;
    logic [1:0]          r_cnt;
    logic [UDM_RESW-1:0] r_result;
    logic [UDM_RESW-1:0] w_mul_res;
    logic                w_any;
    logic                w_accept;
    logic [7:0]          w_valid_ext;
    logic [2:0]          w_last_ext;
    logic [2:0]          w_pick;

    // Arbitration: pick the grant and select that requester's operands.
    // Acceptance is masked while reset is asserted so no ready leaks out.
    always_comb begin
        w_valid_ext = 8'(req_valid_i);
        w_last_ext  = 3'(r_last);
        w_pick      = rr_pick(w_valid_ext, w_last_ext, NREQ);
        w_grant     = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (w_pick == 3'(k)) begin
                w_grant = IDW'(k);
            end
        end
        w_any    = |req_valid_i;
        w_accept = rst_ni && (r_state == IDLE) && w_any;
        w_sel_a  = op_a_i[w_grant*UDM_OPW +: UDM_OPW];
        w_sel_b  = op_b_i[w_grant*UDM_OPW +: UDM_OPW];
    end

    assign req_ready_o = w_accept ? (NREQ'(1) << w_grant) : '0;

    // Next-state logic for the IDLE -> CALC -> RESP transaction sequence.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any)            w_state_nxt = CALC;
            CALC:    if (r_cnt == 2'd0)    w_state_nxt = RESP;
            RESP:    if (rsp_ready_i)      w_state_nxt = IDLE;
            default:                       w_state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Operand capture, multicycle countdown and result register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_op_a   <= '0;
            r_op_b   <= '0;
            r_id     <= '0;
            r_last   <= IDW'(NREQ - 1);
            r_cnt    <= '0;
            r_result <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_op_a <= w_sel_a;
                        r_op_b <= w_sel_b;
                        r_id   <= w_grant;
                        r_last <= w_grant;
                        r_cnt  <= c_CNT_INIT;
                    end
                end
                CALC: begin
                    if (r_cnt != 2'd0) begin
                        r_cnt <= r_cnt - 2'd1;
                    end else begin
                        r_result <= w_mul_res;
                    end
                end
                default: ;
            endcase
        end
    end

    underdesigned_multiplier8 u_mul (
        .operand1_i (r_op_a),
        .operand2_i (r_op_b),
        .result_o   (w_mul_res)
    );

`ifdef UDM_ERR_MON_EN
    logic [UDM_RESW-1:0] w_exact;
    logic [UDM_RESW-1:0] r_err;

    assign w_exact = 16'(r_op_a) * 16'(r_op_b);

    // Error register loads on the same edge as the result register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_err <= '0;
        end else if (r_state == CALC && r_cnt == 2'd0) begin
            r_err <= w_exact - w_mul_res;
        end
    end

    assign rsp_err_o = r_err;
`endif

    assign rsp_valid_o  = (r_state == RESP);
    assign rsp_result_o = r_result;
    assign rsp_id_o     = r_id;
    assign busy_o       = (r_state != IDLE);

endmodule
`default_nettype wire
